// File: rtl/huffman_bit_unpacker.sv
// Word-to-bit unpacker: buffers 32-bit packed words in a small FIFO and streams them MSB-first
// over a valid/ready bit interface. Define HUFF_UNPACK_DROPCNT_EN to enable the dropped-word counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | shifter idle, bit_valid low; loads FIFO head when non-empty
// ST_SHIFT | shifter presents sh[31]; reloads back-to-back on the last bit
module huffman_bit_unpacker #(
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              bit_out,
   output logic              bit_valid,
   input  logic              bit_ready,
   output logic [CNT_W-1:0]  fifo_count,
   output logic              busy,
   output logic              overflow,
   output logic [7:0]        drop_count
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int BCNT_W = $clog2(WORD_W) + 1;

   typedef enum logic {ST_EMPTY, ST_SHIFT} state_t;

   state_t              state, state_nxt;
   logic [WORD_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [WORD_W-1:0]   sh;
   logic [BCNT_W-1:0]   bitcnt;
   logic                ovf;
   logic                hs, last_bit, fifo_empty, fifo_full;
   logic                pop, push, drop;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign hs         = (state == ST_SHIFT) && bit_ready;
   assign last_bit   = (bitcnt == BCNT_W'(1));

   // A write into a full FIFO still lands when the shifter pops in the same cycle.
   assign push = word_valid && (!fifo_full || pop);
   assign drop = word_valid && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_EMPTY;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (hs && last_bit) begin
               if (!fifo_empty) pop       = 1'b1;
               else             state_nxt = ST_EMPTY;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= word_in;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh     <= '0;
         bitcnt <= '0;
      end else if (pop) begin
         sh     <= mem[rd_ptr];
         bitcnt <= BCNT_W'(WORD_W);
      end else if (hs) begin
         sh     <= {sh[WORD_W-2:0], 1'b0};
         bitcnt <= bitcnt - BCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)  ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
   end

`ifdef HUFF_UNPACK_DROPCNT_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n)                         drop_cnt_q <= '0;
      else if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = 8'd0;
`endif

   assign bit_out    = sh[WORD_W-1];
   assign bit_valid  = (state == ST_SHIFT);
   assign fifo_count = count;
   assign busy       = (state == ST_SHIFT) || !fifo_empty;
   assign overflow   = ovf;

endmodule

// File: tb/tb_huffman_bit_unpacker.sv
// Directed bench for huffman_bit_unpacker: vector table for single-word streaming plus
// hand-written sequences for back-to-back words, stalls, overflow, full-with-pop and reset.
module tb_huffman_bit_unpacker;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] word_in;
   logic        word_valid;
   logic        bit_out;
   logic        bit_valid;
   logic        bit_ready;
   logic [2:0]  fifo_count;
   logic        busy;
   logic        overflow;
   logic [7:0]  drop_count;

   always #5 clk = ~clk;

   huffman_bit_unpacker #(.WORD_W(32), .FIFO_DEPTH(4), .CNT_W(3)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .word_in    (word_in),
      .word_valid (word_valid),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .bit_ready  (bit_ready),
      .fifo_count (fifo_count),
      .busy       (busy),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

`ifdef HUFF_UNPACK_DROPCNT_EN
   localparam logic [7:0] EXP_DROP = 8'd1;
`else
   localparam logic [7:0] EXP_DROP = 8'd0;
`endif

   typedef struct {
      logic [31:0] word;
      logic [31:0] exp;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   peak  = 0;
   logic q_bits[$];
   int   q_cyc[$];

   // Every accepted bit is logged with the cycle it was handed over in.
   always @(negedge clk) begin
      cyc++;
      if (reset_n && bit_valid && bit_ready) begin
         q_bits.push_back(bit_out);
         q_cyc.push_back(cyc);
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse(input logic [31:0] w);
      word_in    = w;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
   endtask

   task automatic clear_log();
      q_bits.delete();
      q_cyc.delete();
      peak = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] take_word();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++) begin
         w = {w[30:0], (q_bits.size() > 0) ? q_bits.pop_front() : 1'b0};
         if (q_cyc.size() > 0) void'(q_cyc.pop_front());
      end
      return w;
   endfunction

   function automatic int span();
      return (q_cyc.size() > 0) ? q_cyc[q_cyc.size()-1] - q_cyc[0] : -1;
   endfunction

   vec_t vecs[5];

   initial begin
      vecs[0] = '{word: 32'h8000_0001, exp: 32'h8000_0001};
      vecs[1] = '{word: 32'hDEAD_BEEF, exp: 32'hDEAD_BEEF};
      vecs[2] = '{word: 32'h0000_0000, exp: 32'h0000_0000};
      vecs[3] = '{word: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
      vecs[4] = '{word: 32'h1234_5678, exp: 32'h1234_5678};

      reset_n    = 1'b0;
      word_in    = '0;
      word_valid = 1'b0;
      bit_ready  = 1'b1;
      run(3);
      chk("rst_bit_valid",  32'(bit_valid),  32'd0);
      chk("rst_bit_out",    32'(bit_out),    32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_overflow",   32'(overflow),   32'd0);
      chk("rst_drop_count", 32'(drop_count), 32'd0);
      reset_n = 1'b1;
      tick();

      // single words: latency N+2, 32 contiguous bits MSB-first, then idle
      for (int v = 0; v < 5; v++) begin
         clear_log();
         pulse(vecs[v].word);
         chk("vec_n1_valid", 32'(bit_valid),  32'd0);
         chk("vec_n1_count", 32'(fifo_count), 32'd1);
         chk("vec_n1_busy",  32'(busy),       32'd1);
         tick();
         chk("vec_n2_valid", 32'(bit_valid), 32'd1);
         chk("vec_first_bit", 32'(bit_out), 32'(vecs[v].exp[31]));
         run(40);
         chk("vec_nbits", 32'(q_bits.size()), 32'd32);
         chk("vec_span", 32'(span()), 32'd31);
         chk("vec_word", take_word(), vecs[v].exp);
         chk("vec_idle_valid", 32'(bit_valid), 32'd0);
         chk("vec_idle_busy",  32'(busy),      32'd0);
      end

      // two words two cycles apart stream with no bubble
      clear_log();
      pulse(32'hA5A5_A5A5);
      tick();
      pulse(32'h0F0F_0F0F);
      run(70);
      chk("b2b_nbits", 32'(q_bits.size()), 32'd64);
      chk("b2b_span",  32'(span()),        32'd63);
      chk("b2b_peak",  32'(peak),          32'd1);
      chk("b2b_word0", take_word(), 32'hA5A5_A5A5);
      chk("b2b_word1", take_word(), 32'h0F0F_0F0F);

      // stall after three bits of 0xC0000000
      clear_log();
      pulse(32'hC000_0000);
      tick();
      run(3);
      bit_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", 32'(bit_valid), 32'd1);
         chk("stall_bit",   32'(bit_out),   32'd0);
      end
      bit_ready = 1'b1;
      run(40);
      chk("stall_nbits", 32'(q_bits.size()), 32'd32);
      chk("stall_word", take_word(), 32'hC000_0000);

      // overflow: one word in the shifter, four in the FIFO, sixth dropped
      bit_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         pulse(32'h1111_1111 * k);
         tick();
      end
      chk("ovf_count_full", 32'(fifo_count), 32'd4);
      chk("ovf_before",     32'(overflow),   32'd0);
      pulse(32'h6666_6666);
      chk("ovf_set",        32'(overflow),   32'd1);
      chk("ovf_count_hold", 32'(fifo_count), 32'd4);
      chk("ovf_drop_count", 32'(drop_count), 32'(EXP_DROP));
      clear_log();
      bit_ready = 1'b1;
      run(170);
      chk("ovf_nbits", 32'(q_bits.size()), 32'd160);
      for (int k = 1; k <= 5; k++) chk("ovf_word", take_word(), 32'h1111_1111 * k);
      chk("ovf_sticky",  32'(overflow), 32'd1);
      chk("ovf_drained", 32'(busy),     32'd0);

      // reset mid-word with a word still queued
      pulse(32'hFFFF_FFFF);
      tick();
      pulse(32'h1234_5678);
      run(9);
      chk("mid_pre_count", 32'(fifo_count), 32'd1);
      chk("mid_pre_valid", 32'(bit_valid),  32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mid_valid",    32'(bit_valid),  32'd0);
      chk("mid_count",    32'(fifo_count), 32'd0);
      chk("mid_overflow", 32'(overflow),   32'd0);
      chk("mid_busy",     32'(busy),       32'd0);
      chk("mid_drop",     32'(drop_count), 32'd0);
      clear_log();
      run(5);
      chk("mid_no_stale", 32'(q_bits.size()), 32'd0);
      pulse(32'h3C3C_3C3C);
      run(40);
      chk("mid_nbits", 32'(q_bits.size()), 32'd32);
      chk("mid_word", take_word(), 32'h3C3C_3C3C);

      // FIFO full while the shifter hands over its last bit: coincident write is kept
      bit_ready = 1'b0;
      pulse(32'hA1A1_A1A1);
      tick();
      pulse(32'hB2B2_B2B2);
      pulse(32'hC3C3_C3C3);
      pulse(32'hD4D4_D4D4);
      pulse(32'hE5E5_E5E5);
      chk("fp_count_full", 32'(fifo_count), 32'd4);
      clear_log();
      bit_ready = 1'b1;
      run(31);
      chk("fp_count_31", 32'(fifo_count), 32'd4);
      pulse(32'hF6F6_F6F6);
      chk("fp_count_after", 32'(fifo_count), 32'd4);
      chk("fp_overflow",    32'(overflow),   32'd0);
      chk("fp_drop",        32'(drop_count), 32'd0);
      run(170);
      chk("fp_nbits", 32'(q_bits.size()), 32'd192);
      chk("fp_span",  32'(span()),        32'd191);
      chk("fp_word0", take_word(), 32'hA1A1_A1A1);
      chk("fp_word1", take_word(), 32'hB2B2_B2B2);
      chk("fp_word2", take_word(), 32'hC3C3_C3C3);
      chk("fp_word3", take_word(), 32'hD4D4_D4D4);
      chk("fp_word4", take_word(), 32'hE5E5_E5E5);
      chk("fp_word5", take_word(), 32'hF6F6_F6F6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
